step_counter_sequencer: RTL and testbench
=========================================

Name: step_counter_sequencer

Overview:
Command-driven controller for the 4-bit step counter datapath. It accepts queued commands (LOAD value, step +3 N times, step +1 N times, hold N cycles) over a valid/ready handshake. It drives the counter's load/count_en/c/data_in controls cycle by cycle, then reports the settled count with a done pulse. It sits between a host/test FSM and the counter instance, so the counter's control pins are never driven ad hoc.

Parameters:
FIFO_DEPTH, 4, command queue entries (power of 2, ≥2)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  posedge clock
reset  in  1  async active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  queue not full
cmd_op  in  2  00=STEP3, 01=STEP1, 10=LOAD, 11=HOLD
cmd_arg  in  4  LOAD: data value; others: repeat count N (0..15)
ctr_load  out  1  to counter load
ctr_count_en  out  1  to counter count_en
ctr_c  out  2  to counter c (00=+3, 01=+1, 11=hold)
ctr_data  out  4  to counter data_in
ctr_count  in  4  counter's current count
busy  out  1  FSM not IDLE or queue non-empty
done  out  1  one-cycle pulse per completed command
result  out  4  count captured at completion, held until next done
q_level  out  PTR_W+1  queue occupancy

Behaviour:
- Async reset (reset=0): queue emptied, FSM=IDLE, every output 0 (ctr_c=2'b11 is NOT used at reset; ctr_c=00 with ctr_count_en=0), result=0, done=0. The reset takes effect immediately, including mid-command. No partial command is resumed.
- Queue: push when cmd_valid & cmd_ready; cmd_ready = (q_level < FIFO_DEPTH). When full, cmd_valid is ignored and the command is not stored. Simultaneous push and pop when full is not allowed, because ready is already 0. Simultaneous push and pop at any other level leaves q_level unchanged. Order is FIFO.
- All ctr_* outputs are registered. A value on ctr_* in cycle k is sampled by the counter at the edge ending cycle k.
- FSM states: IDLE, ISSUE, SETTLE, REPORT.
- IDLE: if queue non-empty, pop the head into cur_op/cur_arg, set rem=cur_arg, and go to ISSUE.
- ISSUE, LOAD: assert ctr_load=1 and ctr_data=cur_arg for exactly 1 cycle, then go to SETTLE.
- ISSUE, STEP3/STEP1 with rem>0: assert ctr_count_en=1 and ctr_c=00/01, decrement rem each cycle. Stay in ISSUE until rem reaches 0. This gives exactly N consecutive enable cycles, then SETTLE.
- ISSUE, HOLD with rem>0: assert ctr_count_en=1 and ctr_c=11 for N cycles, then SETTLE.
- ISSUE, N=0 (non-LOAD): no enable cycle is issued; go straight to SETTLE.
- SETTLE: all ctr_* inactive (load=0, count_en=0) for 1 cycle so the last update is visible on ctr_count. Then go to REPORT.
- REPORT: result<=ctr_count, done=1 for 1 cycle, then IDLE. Back-to-back commands each cost 1 (IDLE) + max(N,1 for LOAD, 0) + 1 + 1 cycles.
- The counter's own wrap rule (the next value becomes 0 when the pre-update count is 15 and enable is asserted) is not modelled or corrected. result reports whatever the counter holds.
- ctr_load and ctr_count_en are never asserted in the same cycle.
- busy=1 from the cycle after the first push until the cycle after the final REPORT with the queue empty.

Test Plan:
- Reset mid-STEP3 (N=5, after 2 enables) -> all outputs 0 immediately, q_level=0, FSM IDLE; the counter model shows 0.
- LOAD 4'd7 -> exactly one ctr_load cycle with ctr_data=7; done pulses 3 cycles after the pop with result=7.
- LOAD 2, then STEP3 N=3 -> 3 consecutive enables with c=00; result=11. Then STEP1 N=4 -> enables reach count 15, result=15. Then STEP1 N=1 -> counter wraps (15 seen at update), result=0.
- HOLD N=4 after LOAD 9 -> 4 enable cycles with c=11; result=9. STEP1 N=0 -> zero enables, done still pulses, result unchanged.
- Push 5 commands back-to-back with FIFO_DEPTH=4 while the FSM is stalled in a long STEP1 N=15 -> cmd_ready drops at q_level=4. The 5th command is only accepted after the next pop. All commands complete in order with 5 done pulses.
- Simultaneous push and pop at q_level=2 -> q_level stays 2. At no point are ctr_load and ctr_count_en both 1 (assertion over the whole run).

Source files
------------

// File: rtl/step_counter_sequencer.sv
// rtl/step_counter_sequencer.sv - queued command sequencer driving a 4-bit step counter's control pins
module step_counter_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_arg,
    output logic             ctr_load,
    output logic             ctr_count_en,
    output logic [1:0]       ctr_c,
    output logic [3:0]       ctr_data,
    input  logic [3:0]       ctr_count,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result,
    output logic [PTR_W:0]   q_level
);

    localparam logic [1:0] OP_STEP3 = 2'b00;
    localparam logic [1:0] OP_STEP1 = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_HOLD  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [PTR_W:0] DEPTH_Q = (PTR_W+1)'(FIFO_DEPTH);

    logic [5:0]       q_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [1:0]       head_op;
    logic [3:0]       head_arg;

    logic [1:0]       state;
    logic [1:0]       cur_op;
    logic [3:0]       rem;

    assign cmd_ready = (q_level < DEPTH_Q);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (q_level != '0);
    assign head_op   = q_mem[rd_ptr][5:4];
    assign head_arg  = q_mem[rd_ptr][3:0];
    assign busy      = (state != S_IDLE) || (q_level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {cmd_op, cmd_arg};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W)'(1);
            end
            case ({push, pop})
                2'b10:   q_level <= q_level + (PTR_W+1)'(1);
                2'b01:   q_level <= q_level - (PTR_W+1)'(1);
                default: q_level <= q_level;
            endcase
        end
    end

    // Control pins are set on the edge entering the cycle they apply to, so the
    // counter samples them at the edge that ends that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cur_op       <= OP_STEP3;
            rem          <= '0;
            ctr_load     <= 1'b0;
            ctr_count_en <= 1'b0;
            ctr_c        <= 2'b00;
            ctr_data     <= '0;
            done         <= 1'b0;
            result       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_op <= head_op;
                        rem    <= head_arg;
                        if (head_op == OP_LOAD) begin
                            ctr_load <= 1'b1;
                            ctr_data <= head_arg;
                            state    <= S_ISSUE;
                        end else if (head_arg != 4'd0) begin
                            // Op encoding for STEP3/STEP1/HOLD matches the counter's c code.
                            ctr_count_en <= 1'b1;
                            ctr_c        <= head_op;
                            state        <= S_ISSUE;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cur_op == OP_LOAD) begin
                        ctr_load <= 1'b0;
                        ctr_data <= '0;
                        state    <= S_SETTLE;
                    end else begin
                        rem <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            ctr_count_en <= 1'b0;
                            ctr_c        <= 2'b00;
                            state        <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    result <= ctr_count;
                    done   <= 1'b1;
                    state  <= S_REPORT;
                end
                S_REPORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_counter_sequencer.sv
// tb/tb_step_counter_sequencer.sv - directed bench for step_counter_sequencer with a behavioural counter
module tb_step_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic       ctr_load;
    logic       ctr_count_en;
    logic [1:0] ctr_c;
    logic [3:0] ctr_data;
    logic [3:0] ctr_count;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [2:0] q_level;

    int total;
    int bad;

    int en_cnt;
    int en_run;
    int en_max_run;
    int c_bad;
    logic [1:0] exp_c;
    int load_cnt;
    int done_n;
    int done_log [64];
    logic overlap_seen;

    step_counter_sequencer #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .ctr_load(ctr_load), .ctr_count_en(ctr_count_en), .ctr_c(ctr_c), .ctr_data(ctr_data),
        .ctr_count(ctr_count), .busy(busy), .done(done), .result(result), .q_level(q_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter: wraps to 0 when enabled at 15, otherwise +3 / +1 / hold by c.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctr_count <= 4'd0;
        end else if (ctr_load) begin
            ctr_count <= ctr_data;
        end else if (ctr_count_en) begin
            if (ctr_count == 4'd15) ctr_count <= 4'd0;
            else if (ctr_c == 2'b00) ctr_count <= ctr_count + 4'd3;
            else if (ctr_c == 2'b01) ctr_count <= ctr_count + 4'd1;
        end
    end

    initial begin
        en_cnt = 0; en_run = 0; en_max_run = 0; c_bad = 0; exp_c = 2'b00;
        load_cnt = 0; done_n = 0; overlap_seen = 1'b0;
    end

    always @(negedge clk) begin
        if (ctr_load && ctr_count_en) overlap_seen = 1'b1;
        if (ctr_load) load_cnt++;
        if (ctr_count_en) begin
            en_cnt++;
            en_run++;
            if (en_run > en_max_run) en_max_run = en_run;
            if (ctr_c !== exp_c) c_bad++;
        end else begin
            en_run = 0;
        end
        if (done) begin
            if (done_n < 64) done_log[done_n] = int'(result);
            done_n++;
        end
    end

    task automatic clear_mon(input logic [1:0] c);
        en_cnt = 0; en_max_run = 0; c_bad = 0; load_cnt = 0; exp_c = c;
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL push_timeout: cmd_ready stayed %0b, required 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done_pulse(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n;
        n = 0;
        while (done_n < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (done_n < target) begin
            bad++;
            $display("FAIL dones_timeout: got %0d done pulses, required %0d", done_n, target);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ctr_load, ctr_count_en, ctr_c, ctr_data} !== 8'h00) begin
            bad++; $display("FAIL reset_ctr: got %02h, required 00", {ctr_load, ctr_count_en, ctr_c, ctr_data});
        end
        total++;
        if ({busy, done, result, q_level} !== 9'h000) begin
            bad++; $display("FAIL reset_status: got %03h, required 000", {busy, done, result, q_level});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release: ready=%0b busy=%0b, required 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_load;
        clear_mon(2'b00);
        push_cmd(2'b10, 4'd7);
        total++;
        if (busy !== 1'b1 || q_level !== 3'd1) begin
            bad++; $display("FAIL load_queued: busy=%0b q=%0d, required 1 1", busy, q_level);
        end
        @(negedge clk);
        total++;
        if (ctr_load !== 1'b1 || ctr_data !== 4'd7 || ctr_count_en !== 1'b0) begin
            bad++; $display("FAIL load_issue: load=%0b data=%0d en=%0b, required 1 7 0", ctr_load, ctr_data, ctr_count_en);
        end
        @(negedge clk);
        total++;
        if (ctr_load !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL load_settle: load=%0b done=%0b, required 0 0", ctr_load, done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || result !== 4'd7) begin
            bad++; $display("FAIL load_report: done=%0b result=%0d, required 1 7", done, result);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 4'd7 || load_cnt != 1) begin
            bad++; $display("FAIL load_after: done=%0b busy=%0b result=%0d loads=%0d, required 0 0 7 1", done, busy, result, load_cnt);
        end
    endtask

    task automatic test_steps;
        push_cmd(2'b10, 4'd2);
        wait_done_pulse(20);
        @(negedge clk);
        clear_mon(2'b00);
        push_cmd(2'b00, 4'd3);
        wait_done_pulse(30);
        total++;
        if (result !== 4'd11) begin
            bad++; $display("FAIL step3_result: got %0d, required 11", result);
        end
        @(negedge clk);
        total++;
        if (en_cnt != 3 || en_max_run != 3 || c_bad != 0) begin
            bad++; $display("FAIL step3_enables: en=%0d run=%0d cbad=%0d, required 3 3 0", en_cnt, en_max_run, c_bad);
        end
        clear_mon(2'b01);
        push_cmd(2'b01, 4'd4);
        wait_done_pulse(30);
        total++;
        if (result !== 4'd15) begin
            bad++; $display("FAIL step1_to15: got %0d, required 15", result);
        end
        @(negedge clk);
        total++;
        if (en_cnt != 4 || c_bad != 0) begin
            bad++; $display("FAIL step1_enables: en=%0d cbad=%0d, required 4 0", en_cnt, c_bad);
        end
        push_cmd(2'b01, 4'd1);
        wait_done_pulse(30);
        total++;
        if (result !== 4'd0) begin
            bad++; $display("FAIL step1_wrap: got %0d, required 0", result);
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        push_cmd(2'b10, 4'd9);
        wait_done_pulse(20);
        @(negedge clk);
        clear_mon(2'b11);
        push_cmd(2'b11, 4'd4);
        wait_done_pulse(30);
        total++;
        if (result !== 4'd9) begin
            bad++; $display("FAIL hold_result: got %0d, required 9", result);
        end
        @(negedge clk);
        total++;
        if (en_cnt != 4 || en_max_run != 4 || c_bad != 0) begin
            bad++; $display("FAIL hold_enables: en=%0d run=%0d cbad=%0d, required 4 4 0", en_cnt, en_max_run, c_bad);
        end
        clear_mon(2'b01);
        push_cmd(2'b01, 4'd0);
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL n0_early: done=%0b, required 0", done);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || result !== 4'd9) begin
            bad++; $display("FAIL n0_report: done=%0b result=%0d, required 1 9", done, result);
        end
        @(negedge clk);
        total++;
        if (en_cnt != 0) begin
            bad++; $display("FAIL n0_enables: en=%0d, required 0", en_cnt);
        end
    endtask

    task automatic test_queue_full;
        int base;
        int expv [6];
        expv = '{8, 1, 7, 10, 10, 13};
        base = done_n;
        push_cmd(2'b01, 4'd15);
        @(negedge clk);
        push_cmd(2'b10, 4'd1);
        push_cmd(2'b00, 4'd2);
        push_cmd(2'b01, 4'd3);
        push_cmd(2'b11, 4'd1);
        total++;
        if (q_level !== 3'd4 || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL full_level: q=%0d ready=%0b, required 4 0", q_level, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (q_level !== 3'd4 || cmd_ready !== 1'b0) begin
                bad++; $display("FAIL full_ignore: q=%0d ready=%0b, required 4 0", q_level, cmd_ready);
            end
        end
        push_cmd(2'b00, 4'd1);
        total++;
        if (done_n - base != 1) begin
            bad++; $display("FAIL full_accept_time: dones before 5th accept=%0d, required 1", done_n - base);
        end
        wait_dones(base + 6, 300);
        for (int i = 0; i < 6; i++) begin
            total++;
            if (done_log[base + i] != expv[i]) begin
                bad++; $display("FAIL full_order[%0d]: result %0d, required %0d", i, done_log[base + i], expv[i]);
            end
        end
    endtask

    task automatic test_push_pop;
        int base;
        int expv [4];
        expv = '{0, 0, 0, 1};
        base = done_n;
        push_cmd(2'b01, 4'd3);
        @(negedge clk);
        push_cmd(2'b11, 4'd1);
        push_cmd(2'b11, 4'd2);
        wait_done_pulse(20);
        @(negedge clk);
        total++;
        if (q_level !== 3'd2 || cmd_ready !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL pp_before: q=%0d ready=%0b busy=%0b, required 2 1 1", q_level, cmd_ready, busy);
        end
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_arg = 4'd1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (q_level !== 3'd2) begin
            bad++; $display("FAIL pp_level: q=%0d, required 2", q_level);
        end
        wait_dones(base + 4, 200);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (done_log[base + i] != expv[i]) begin
                bad++; $display("FAIL pp_order[%0d]: result %0d, required %0d", i, done_log[base + i], expv[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        push_cmd(2'b00, 4'd5);
        @(negedge clk);
        push_cmd(2'b10, 4'd3);
        total++;
        if (ctr_count_en !== 1'b1 || ctr_count !== 4'd4 || q_level !== 3'd1) begin
            bad++; $display("FAIL mid_pre: en=%0b count=%0d q=%0d, required 1 4 1", ctr_count_en, ctr_count, q_level);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({ctr_load, ctr_count_en, ctr_c, ctr_data} !== 8'h00 || ctr_count !== 4'd0) begin
            bad++; $display("FAIL mid_ctr: ctr=%02h count=%0d, required 00 0", {ctr_load, ctr_count_en, ctr_c, ctr_data}, ctr_count);
        end
        total++;
        if ({busy, done, result, q_level} !== 9'h000) begin
            bad++; $display("FAIL mid_status: got %03h, required 000", {busy, done, result, q_level});
        end
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || ctr_count_en || ctr_load) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL mid_no_resume: %0d active cycles, required 0", stray);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_load();
        test_steps();
        test_hold();
        test_queue_full();
        test_push_pop();
        test_reset_mid();
        total++;
        if (overlap_seen !== 1'b0) begin
            bad++; $display("FAIL load_en_overlap: seen=%0b, required 0", overlap_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
